// File: rtl/recfn_pkg.sv
// Shared constants and helpers for the IEEE-to-recoded float converter.
package recfn_pkg;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Input classification carried from stage 1 to stage 2
  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  // Top three bits of the recoded exponent for the special classes
  localparam logic [2:0] TOP_ZERO = 3'b000;
  localparam logic [2:0] TOP_INF  = 3'b110;
  localparam logic [2:0] TOP_NAN  = 3'b111;

  // Recoded exponent bias B = 2^(E-1) + 1
  function automatic int rec_bias(input int exp_width);
    return (1 << (exp_width - 1)) + 1;
  endfunction

endpackage

// File: rtl/recfn_count_lz.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module recfn_count_lz
  import recfn_pkg::*;
#(
  parameter  int WIDTH = 23,
  localparam int LZ_W  = clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] fract_i,
  output logic [LZ_W-1:0]  lz_o
);

  // NOTE: the output gets a default before the loop so no latch is inferred.
  always_comb begin
    lz_o = LZ_W'(WIDTH);
    // Ascending scan: the last hit is the most significant set bit
    for (int i = 0; i < WIDTH; i++) begin
      if (fract_i[i]) lz_o = LZ_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/float_to_recoded_float_pipe.sv
// Two-stage ready/valid converter from IEEE binary to the hardfloat recoded format.
// Define CANONICAL_NAN_EN to replace every NaN with the canonical quiet NaN.
module float_to_recoded_float_pipe
  import recfn_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 24
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH-1:0] in_bits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_WIDTH+SIG_WIDTH:0] out_bits,
  output logic                         out_is_snan
);

  localparam int              F    = SIG_WIDTH - 1;
  localparam int              LZ_W = clog2(F) + 1;
  localparam int              RW   = EXP_WIDTH + 1;
  localparam logic [RW-1:0]   BIAS = RW'(rec_bias(EXP_WIDTH));

  logic                 in_sign;
  logic [EXP_WIDTH-1:0] in_exp;
  logic [F-1:0]         in_fract;
  logic [LZ_W-1:0]      in_lz;
  logic [2:0]           cls_d;

  logic                 s1_valid_q, s1_sign_q;
  logic [EXP_WIDTH-1:0] s1_exp_q;
  logic [F-1:0]         s1_fract_q;
  logic [LZ_W-1:0]      s1_lz_q;
  logic [2:0]           s1_cls_q;

  logic                 out_valid_q, out_is_snan_q, out_is_snan_d;
  logic [RW+F:0]        out_bits_q, out_bits_d;
  logic                 en1, en2;

  assign {in_sign, in_exp, in_fract} = in_bits;

  // Stalls only when the stage downstream is full and not draining
  assign en2      = ~out_valid_q | out_ready;
  assign en1      = ~s1_valid_q | en2;
  assign in_ready = en1;

  recfn_count_lz #(.WIDTH(F)) u_count_lz (
    .fract_i (in_fract),
    .lz_o    (in_lz)
  );

  always_comb begin
    cls_d = CLS_NORM;
    if (in_exp == '0)      cls_d = (in_fract == '0) ? CLS_ZERO : CLS_SUB;
    else if (&in_exp)      cls_d = (in_fract == '0) ? CLS_INF  : CLS_NAN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_fract_q <= '0;
      s1_lz_q    <= '0;
      s1_cls_q   <= CLS_ZERO;
    end else if (en1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q  <= in_sign;
        s1_exp_q   <= in_exp;
        s1_fract_q <= in_fract;
        s1_lz_q    <= in_lz;
        s1_cls_q   <= cls_d;
      end
    end
  end

  // Stage 2: normalise subnormals and rebias the exponent modulo 2^(E+1)
  logic            sign_d;
  logic [RW-1:0]   rexp_d;
  logic [F-1:0]    rfract_d;
  logic [F-1:0]    sub_fract;

  // Shifting by lz+1 also drops the leading one, which becomes the hidden bit
  assign sub_fract = s1_fract_q << (s1_lz_q + LZ_W'(1));

  always_comb begin
    sign_d   = s1_sign_q;
    rexp_d   = RW'(s1_exp_q) + BIAS;
    rfract_d = s1_fract_q;
    case (s1_cls_q)
      CLS_ZERO: begin
        rexp_d   = {TOP_ZERO, {(RW-3){1'b0}}};
        rfract_d = '0;
      end
      CLS_SUB: begin
        rexp_d   = BIAS - RW'(s1_lz_q);
        rfract_d = sub_fract;
      end
      CLS_INF: rexp_d = {TOP_INF, {(RW-3){1'b0}}};
      CLS_NAN: begin
        rexp_d = {TOP_NAN, {(RW-3){1'b0}}};
`ifdef CANONICAL_NAN_EN
        sign_d   = 1'b0;
        rfract_d = {1'b1, {(F-1){1'b0}}};
`endif
      end
      default: ;
    endcase
    out_bits_d    = {sign_d, rexp_d, rfract_d};
    out_is_snan_d = (s1_cls_q == CLS_NAN) & ~s1_fract_q[F-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_bits_q    <= '0;
      out_is_snan_q <= 1'b0;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_bits_q    <= out_bits_d;
        out_is_snan_q <= out_is_snan_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bits    = out_bits_q;
  assign out_is_snan = out_is_snan_q;

endmodule

// File: tb/tb_float_to_recoded_float_pipe.sv
// Self-checking bench for float_to_recoded_float_pipe (E=8, S=24): directed vectors,
// back-pressure, random traffic against an arithmetic reference model, and mid-flight reset.
module tb_float_to_recoded_float_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_bits;
  logic        out_is_snan;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] exp_q[$];
  logic        acc, seen_out, prev_stall;
  logic [32:0] prev_bits, last_bits;
  logic        last_snan;

  float_to_recoded_float_pipe #(.EXP_WIDTH(8), .SIG_WIDTH(24)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .out_is_snan (out_is_snan)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: {snan, sign, rexp[8:0], rfract[22:0]} from the IEEE bit fields
  function automatic logic [33:0] model(input logic [31:0] v);
    logic s;
    int   e, f, m, sh, rexp, rf;
    logic nan;
    s   = v[31];
    e   = int'(v[30:23]);
    f   = int'(v[22:0]);
    nan = 1'b0;
    if (e == 0 && f == 0) begin
      rexp = 0;
      rf   = 0;
    end else if (e == 0) begin
      m  = f;
      sh = 0;
      while (m < 'h800000) begin
        m  = m * 2;
        sh++;
      end
      rexp = 129 - (sh - 1);
      rf   = m - 'h800000;
    end else if (e == 255) begin
      nan  = (f != 0);
      rexp = nan ? 'h1C0 : 'h180;
      rf   = f;
    end else begin
      rexp = (e + 129) % 512;
      rf   = f;
    end
`ifdef CANONICAL_NAN_EN
    if (nan) return {(f < 'h400000), 1'b0, 9'h1C0, 23'h400000};
`endif
    return {nan && (f < 'h400000), s, 9'(rexp), 23'(rf)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [22:0] f;
    logic [31:0] r;
    f = 23'($urandom) >> $urandom_range(0, 22);
    if (f == '0) f = 23'd1;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31], 31'd0};
      1:       return {r[31], 8'h00, f};
      2:       return {r[31], 8'hFF, 23'd0};
      3:       return {r[31], 8'hFF, r[22] ? r[22:0] : f};
      default: return r;
    endcase
  endfunction

  // One cycle: sample at negedge+1, update scoreboard, advance to next negedge
  task automatic step();
    logic [33:0] e;
    #1;
    acc      = in_valid && in_ready;
    seen_out = out_valid && out_ready;
    if (prev_stall) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_bits", 64'(out_bits), 64'(prev_bits));
    end
    if (acc) exp_q.push_back(model(in_bits));
    if (seen_out) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_bits", 64'(out_bits), 64'(e[32:0]));
        check("sb_snan", 64'(out_is_snan), 64'(e[33]));
      end
    end
    last_bits  = out_bits;
    last_snan  = out_is_snan;
    prev_stall = out_valid && !out_ready;
    prev_bits  = out_bits;
    @(negedge clock);
  endtask

  task automatic send_dir(input string tag, input logic [31:0] v, input logic [32:0] want,
                          input logic want_snan);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bits   = v;
    step();
    check({tag, "_acc"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!seen_out && lat < 10);
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_bits"}, 64'(last_bits), 64'(want));
    check({tag, "_snan"}, 64'(last_snan), 64'(want_snan));
  endtask

  initial begin
    logic [31:0] beats[4];
    int idx, cyc, sent;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_bits    = '0;
    out_ready  = 1'b0;
    prev_stall = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_bits", 64'(out_bits), 64'd0);
    check("rst_out_snan", 64'(out_is_snan), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    send_dir("one",     32'h3F800000, 33'h0_8000_0000, 1'b0);
    send_dir("minsub",  32'h00000001, 33'h0_3580_0000, 1'b0);
    send_dir("topsub",  32'h00400000, 33'h0_4080_0000, 1'b0);
    send_dir("negzero", 32'h80000000, 33'h1_0000_0000, 1'b0);
    send_dir("inf",     32'h7F800000, 33'h0_C000_0000, 1'b0);
    send_dir("qnan",    32'h7FC00000, 33'h0_E040_0000, 1'b0);
`ifdef CANONICAL_NAN_EN
    send_dir("snan",    32'h7F800001, 33'h0_E040_0000, 1'b1);
    send_dir("negnan",  32'hFFA00000, 33'h0_E040_0000, 1'b1);
`else
    send_dir("snan",    32'h7F800001, 33'h0_E000_0001, 1'b1);
    send_dir("negnan",  32'hFFA00000, 33'h1_E020_0000, 1'b1);
`endif

    // Back-pressure: 2 accepts then 5 stalled cycles, then release
    beats = '{32'h3F800000, 32'h00000001, 32'h7F800001, 32'hC0490FDB};
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      in_bits  = beats[idx];
      step();
      if (acc) idx++;
      if (c >= 2) check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    check("bp_accepted", 64'(idx), 64'd2);
    out_ready = 1'b1;
    cyc = 0;
    while ((idx < 4 || exp_q.size() != 0) && cyc < 20) begin
      in_valid = (idx < 4);
      in_bits  = beats[idx < 4 ? idx : 0];
      step();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 64'(idx), 64'd4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic at 50% valid / 50% ready
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 1) == 1);
      in_bits   = rand_fp();
      out_ready = ($urandom_range(0, 1) == 1);
      step();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_sent", 64'(sent), 64'd10000);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_bits  = 32'h40490FDB;
      step();
      check("rst_fill_acc", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_bits", 64'(out_bits), 64'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
